// File: rtl/bcd_seg_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_seg_scanner
//  Brief    : Time-multiplexed 6-digit common-anode 7-segment scanner for a
//             24-bit packed BCD word. The word is snapshotted once per frame.
//             Each digit slot opens with an all-off guard gap to suppress
//             ghosting.
//  Options  : define LEADING_ZERO_BLANK_EN to darken leading zero digits 5..3.
//  Revision : 1.0 - initial release
// ============================================================================
module bcd_seg_scanner #(
    parameter int DIV        = 50000,  // clk cycles per digit slot, >= GUARD+2
    parameter int GUARD      = 500,    // all-off cycles at slot start, >= 1
    parameter int SEG_ACT_LO = 1,      // 1: seg/dp active-low
    parameter int AN_ACT_LO  = 1       // 1: an active-low
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] data_in,
    input  logic [5:0]  dp_mask,
    input  logic        blank,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [5:0]  an,
    output logic        frame_tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] C_CNT_MAX    = CW'(DIV - 1);
    localparam logic [CW-1:0] C_GUARD_LAST = CW'(GUARD - 1);
    localparam logic [2:0]    C_SLOT_MAX   = 3'd5;

    // XOR masks that double as the inactive level of each output
    localparam logic [6:0] C_SEG_OFF = (SEG_ACT_LO != 0) ? 7'h7F : 7'h00;
    localparam logic       C_DP_OFF  = (SEG_ACT_LO != 0) ? 1'b1  : 1'b0;
    localparam logic [5:0] C_AN_OFF  = (AN_ACT_LO  != 0) ? 6'h3F : 6'h00;

    typedef enum logic [0:0] {
        ST_GUARD = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      slot_q, slot_d;
    logic [23:0]     snap_q, snap_d;
    logic [5:0]      dpm_q, dpm_d;

    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic [5:0]      an_q, an_d;
    logic            frame_tick_q, frame_tick_d;

    logic            w_cnt_wrap;
    logic            w_frame_start;
    logic [3:0]      w_digit;
    logic            w_dp_bit;
    logic            w_lz_hide;
    logic [5:0]      w_lz_mask;
    logic [5:0]      w_onehot;

    // Segment pattern in active-high form; non-BCD codes show a dash
    function automatic logic [6:0] f_decode(input logic [3:0] d);
        logic [6:0] r;
        case (d)
            4'd0:    r = 7'h3F;
            4'd1:    r = 7'h06;
            4'd2:    r = 7'h5B;
            4'd3:    r = 7'h4F;
            4'd4:    r = 7'h66;
            4'd5:    r = 7'h6D;
            4'd6:    r = 7'h7D;
            4'd7:    r = 7'h07;
            4'd8:    r = 7'h7F;
            4'd9:    r = 7'h6F;
            default: r = 7'h40;
        endcase
        return r;
    endfunction

    // Slot timing counters: cnt runs 0..DIV-1, slot advances on cnt wrap
    always_comb begin
        w_cnt_wrap    = (cnt_q == C_CNT_MAX);
        w_frame_start = (slot_q == 3'd0) && (cnt_q == '0);
        cnt_d         = w_cnt_wrap ? '0 : cnt_q + 1'b1;
        slot_d        = slot_q;
        if (w_cnt_wrap) begin
            slot_d = (slot_q == C_SLOT_MAX) ? 3'd0 : slot_q + 3'd1;
        end
    end

    // Digit and decimal-point select from the frame snapshot
    always_comb begin
        w_digit  = 4'h0;
        w_dp_bit = 1'b0;
        case (slot_q)
            3'd0: begin w_digit = snap_q[3:0];   w_dp_bit = dpm_q[0]; end
            3'd1: begin w_digit = snap_q[7:4];   w_dp_bit = dpm_q[1]; end
            3'd2: begin w_digit = snap_q[11:8];  w_dp_bit = dpm_q[2]; end
            3'd3: begin w_digit = snap_q[15:12]; w_dp_bit = dpm_q[3]; end
            3'd4: begin w_digit = snap_q[19:16]; w_dp_bit = dpm_q[4]; end
            3'd5: begin w_digit = snap_q[23:20]; w_dp_bit = dpm_q[5]; end
            default: begin w_digit = 4'h0; w_dp_bit = 1'b0; end
        endcase
        w_onehot = 6'b000001 << slot_q;
    end

    // Leading-zero suppression mask for the upper three digits
    always_comb begin
        w_lz_mask = 6'b000000;
`ifdef LEADING_ZERO_BLANK_EN
        w_lz_mask[5] = (snap_q[23:20] == 4'h0);
        w_lz_mask[4] = w_lz_mask[5] && (snap_q[19:16] == 4'h0);
        w_lz_mask[3] = w_lz_mask[4] && (snap_q[15:12] == 4'h0);
`endif
        w_lz_hide = |(w_lz_mask & w_onehot);
    end

    // Guard/drive phase register and counter state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_GUARD;
            cnt_q   <= '0;
            slot_q  <= 3'd0;
            snap_q  <= 24'h000000;
            dpm_q   <= 6'b000000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            snap_q  <= snap_d;
            dpm_q   <= dpm_d;
        end
    end

    // Phase transitions, frame snapshot and next output values
    always_comb begin
        state_d      = state_q;
        snap_d       = snap_q;
        dpm_d        = dpm_q;
        frame_tick_d = w_frame_start;
        seg_d        = C_SEG_OFF;
        dp_d         = C_DP_OFF;
        an_d         = C_AN_OFF;

        if (w_frame_start) begin
            snap_d = data_in;
            dpm_d  = dp_mask;
        end

        case (state_q)
            ST_GUARD: begin
                if (cnt_q == C_GUARD_LAST) begin
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (!w_lz_hide) begin
                    seg_d = f_decode(w_digit) ^ C_SEG_OFF;
                    dp_d  = w_dp_bit ^ C_DP_OFF;
                    if (!blank) begin
                        an_d = w_onehot ^ C_AN_OFF;
                    end
                end
                if (cnt_q == C_CNT_MAX) begin
                    state_d = ST_GUARD;
                end
            end
            default: state_d = ST_GUARD;
        endcase
    end

    // Registered outputs, one clk behind the (slot,cnt) they describe
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_q        <= C_SEG_OFF;
            dp_q         <= C_DP_OFF;
            an_q         <= C_AN_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule
`default_nettype wire
